// File: rtl/alu181_nibble_sequencer.sv
// Runs a WIDTH-bit 74181 operation through one external 4-bit slice, one nibble per
// clock LSB first, chaining the slice carry and assembling the result in a shadow register.
module alu181_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_select,
  input  logic             op_mode,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_select,
  output logic             alu_mode,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q;
  logic             busy_q, done_q, carry_q;
  logic [3:0]       alu_a_q, alu_b_q, sel_q;
  logic             mode_q, cin_q;
  logic [3:0]       nib_a_d, nib_b_d;

  // Merge the slice output for the current nibble into the shadow and pick the next nibble.
  always_comb begin
    k_d                        = k_q + 1'b1;
    shadow_d                   = shadow_q;
    shadow_d[{k_q, 2'b00} +: 4] = alu_f;
    nib_a_d                    = a_q[{k_d, 2'b00} +: 4];
    nib_b_d                    = b_q[{k_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      // NOTE: the shadow is ordinary flops, not a RAM, so it is reset along with everything else.
      shadow_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
    end else begin
      // NOTE: done defaults low here so it can only ever be a one-cycle pulse.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sel_q   <= op_select;
            mode_q  <= op_mode;
            alu_a_q <= op_a[3:0];
            alu_b_q <= op_b[3:0];
            cin_q   <= op_cin;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          shadow_q <= shadow_d;
          if (k_q == K_LAST) begin
            result_q <= shadow_d;
            carry_q  <= alu_cout;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            alu_a_q <= nib_a_d;
            alu_b_q <= nib_b_d;
            cin_q   <= alu_cout;
            k_q     <= k_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign carry_out  = carry_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = sel_q;
  assign alu_mode   = mode_q;
  assign alu_cin    = cin_q;

endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Directed bench for alu181_nibble_sequencer (WIDTH=16) with a behavioural 74181 slice
// attached; expected results are hand-computed.
module tb_alu181_nibble_sequencer;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk, rst, start;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       op_select;
  logic             op_mode, op_cin;
  logic             busy, done, carry_out;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_a, alu_b, alu_select, alu_f;
  logic             alu_mode, alu_cin, alu_cout;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] prev_res;

  alu181_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_select(op_select), .op_mode(op_mode), .op_cin(op_cin),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout)
  );

  // DM74LS181 with active-high data: F = X plus Y plus carry (arithmetic), ~(X^Y) (logic).
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx       = alu_a | (alu_b & {4{alu_select[0]}}) | (~alu_b & {4{alu_select[1]}});
    sy       = (alu_a & ~alu_b & {4{alu_select[2]}}) | (alu_a & alu_b & {4{alu_select[3]}});
    ssum     = {1'b0, sx} + {1'b0, sy} + {4'b0000, ~alu_cin};
    alu_f    = alu_mode ? ~(sx ^ sy) : ssum[3:0];
    alu_cout = ~ssum[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from start to the done cycle; poke re-asserts start with junk mid-op.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cin,
                       input logic [15:0] exp_res, input logic exp_co,
                       input logic exp_cin1, input bit poke);
    op_a = a; op_b = b; op_select = s; op_mode = m; op_cin = cin; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "/busy_e0"}, busy, 1);
    check({tag, "/done_e0"}, done, 0);
    check({tag, "/alu_a_e0"}, alu_a, a[3:0]);
    check({tag, "/alu_b_e0"}, alu_b, b[3:0]);
    check({tag, "/alu_cin_e0"}, alu_cin, cin);
    check({tag, "/alu_sel"}, alu_select, s);
    check({tag, "/alu_mode"}, alu_mode, m);
    for (int i = 1; i < NIB; i++) begin
      if (poke && i == 1) begin
        op_a = 16'hFFFF; op_b = 16'hFFFF; op_select = 4'hF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      check({tag, "/done_mid"}, done, 0);
      check({tag, "/busy_mid"}, busy, 1);
      check({tag, "/result_hold"}, result, prev_res);
      check({tag, "/alu_a_mid"}, alu_a, a[4*i +: 4]);
      check({tag, "/alu_sel_mid"}, alu_select, s);
      if (i == 1) check({tag, "/alu_cin_chain"}, alu_cin, exp_cin1);
    end
    start = 1'b0;
    tick();
    check({tag, "/done"}, done, 1);
    check({tag, "/busy_end"}, busy, 0);
    check({tag, "/result"}, result, exp_res);
    check({tag, "/carry_out"}, carry_out, exp_co);
    prev_res = exp_res;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; op_select = '0; op_mode = 1'b0; op_cin = 1'b0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/result", result, 0);
    check("rst/carry_out", carry_out, 0);
    check("rst/alu_a", alu_a, 0);
    check("rst/alu_b", alu_b, 0);
    check("rst/alu_select", alu_select, 0);
    check("rst/alu_mode", alu_mode, 0);
    check("rst/alu_cin", alu_cin, 0);
    rst = 1'b0;
    tick();
    tick();
    check("idle/busy", busy, 0);
    check("idle/done", done, 0);

    do_op("add",    16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_op("sub",    16'h0100, 16'h0001, 4'b0110, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b1, 1'b0);
    do_op("and",    16'hF0F0, 16'h3C3C, 4'b1011, 1'b1, 1'b1, 16'h3030, 1'b0, 1'b1, 1'b0);
    do_op("xor",    16'hF0F0, 16'h3C3C, 4'b0110, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0);
    tick();
    check("xor/done_pulse", done, 0);

    do_op("poke",   16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1);
    tick();
    check("poke/single_done", done, 0);
    check("poke/idle", busy, 0);

    op_a = 16'hAAAA; op_b = 16'h5555; op_select = 4'b1001; op_mode = 1'b0; op_cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst/busy", busy, 0);
    check("midrst/done", done, 0);
    check("midrst/result", result, 0);
    check("midrst/carry_out", carry_out, 0);
    check("midrst/alu_a", alu_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_res = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst/no_done", done, 0);
    end
    check("midrst/idle", busy, 0);

    do_op("after_rst", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
